// File: rtl/dpram_arb_pkg.sv
// Shared widths, request bundle and cross-port conflict rule for the dual-port SRAM front-end.
// No timing of its own; the conflict check is purely combinational.
// No backpressure of its own; callers gate the function inputs with their own ready terms.
package dpram_arb_pkg;

    localparam int DPRAM_ADDR_WIDTH = 11;
    localparam int DPRAM_BITS       = 32;

    typedef struct packed {
        logic                        we;
        logic [DPRAM_ADDR_WIDTH-1:0] addr;
        logic [DPRAM_BITS-1:0]       wd;
        logic [DPRAM_BITS-1:0]       mask;
    } dpram_req_t;

    // Same word touched by both ports with at least one write; read/read is harmless.
    function automatic logic req_conflict(input dpram_req_t a, input dpram_req_t b,
                                          input logic go_a, input logic go_b);
        return go_a && go_b && (a.addr == b.addr) && (a.we || b.we);
    endfunction

endpackage

// File: rtl/dpram_arb_rsp_fifo.sv
// Per-port read-response FIFO with occupancy count; output comes straight from storage.
// Latency: push at edge N is visible on pop_vld/pop_data after edge N, no bypass.
// Backpressure: holds data until pop; upstream credits guarantee it never overflows.
module dpram_arb_rsp_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic                       pop_vld,
    output logic [WIDTH-1:0]           pop_data,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr, rd_ptr;
    logic [CW-1:0]    cnt;
    logic             do_pop;

    function automatic logic [PW-1:0] ptr_nxt(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign pop_vld  = (cnt != '0);
    assign pop_data = mem[rd_ptr];
    assign count    = cnt;
    assign do_pop   = pop && pop_vld;

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push)   wr_ptr <= ptr_nxt(wr_ptr);
            if (do_pop) rd_ptr <= ptr_nxt(rd_ptr);
            case ({push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && cnt == CW'(DEPTH)));

endmodule

// File: rtl/dpram_arb_front.sv
// Request front-end driving the 2048x32 dual-port SRAM macro; optional stats via DPRAM_ARB_STATS_EN.
// Latency: requests issue combinationally; read data reaches rsp_* two cycles after accept.
// Backpressure: per-port credits cover in-flight reads plus FIFO entries; B yields to A on conflicts.
module dpram_arb_front
    import dpram_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = DPRAM_ADDR_WIDTH,
    parameter int BITS       = DPRAM_BITS,
    parameter int RSP_DEPTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid_A,
    output logic                  req_ready_A,
    input  logic                  req_we_A,
    input  logic [ADDR_WIDTH-1:0] req_addr_A,
    input  logic [BITS-1:0]       req_wd_A,
    input  logic [BITS-1:0]       req_mask_A,
    input  logic                  req_valid_B,
    output logic                  req_ready_B,
    input  logic                  req_we_B,
    input  logic [ADDR_WIDTH-1:0] req_addr_B,
    input  logic [BITS-1:0]       req_wd_B,
    input  logic [BITS-1:0]       req_mask_B,
    output logic                  rsp_valid_A,
    input  logic                  rsp_ready_A,
    output logic [BITS-1:0]       rsp_data_A,
    output logic                  rsp_valid_B,
    input  logic                  rsp_ready_B,
    output logic [BITS-1:0]       rsp_data_B,
    output logic                  ram_ce,
    output logic                  ram_we_A,
    output logic [ADDR_WIDTH-1:0] ram_addr_A,
    output logic [BITS-1:0]       ram_wd_A,
    output logic [BITS-1:0]       ram_mask_A,
    output logic                  ram_we_B,
    output logic [ADDR_WIDTH-1:0] ram_addr_B,
    output logic [BITS-1:0]       ram_wd_B,
    output logic [BITS-1:0]       ram_mask_B,
    input  logic [BITS-1:0]       ram_rd_A,
    input  logic [BITS-1:0]       ram_rd_B
`ifdef DPRAM_ARB_STATS_EN
    ,
    output logic [15:0]           stat_conflict,
    output logic [31:0]           stat_reads
`endif
);
    localparam int            CW       = $clog2(RSP_DEPTH + 1);
    localparam logic [CW-1:0] CRED_MAX = CW'(RSP_DEPTH);

    dpram_req_t             req_a, req_b;
    logic [CW-1:0]          cred_a, cred_b, cnt_a, cnt_b;
    logic                   base_rdy_a, base_rdy_b, conflict;
    logic                   acc_a, acc_b, rd_acc_a, rd_acc_b, pop_a, pop_b;
    logic                   inflight_a, inflight_b;
    logic [ADDR_WIDTH-1:0]  last_addr_a, last_addr_b;

    assign req_a = '{we: req_we_A, addr: req_addr_A, wd: req_wd_A, mask: req_mask_A};
    assign req_b = '{we: req_we_B, addr: req_addr_B, wd: req_wd_B, mask: req_mask_B};

    // rst_n gating keeps ready (and therefore every macro pin) quiet while reset is held.
    assign base_rdy_a = rst_n && ((cred_a < CRED_MAX) || req_we_A);
    assign base_rdy_b = rst_n && ((cred_b < CRED_MAX) || req_we_B);
    assign conflict   = req_conflict(req_a, req_b, req_valid_A && base_rdy_a,
                                     req_valid_B && base_rdy_b);

    assign req_ready_A = base_rdy_a;
    assign req_ready_B = base_rdy_b && !conflict;

    assign acc_a    = req_valid_A && req_ready_A;
    assign acc_b    = req_valid_B && req_ready_B;
    assign rd_acc_a = acc_a && !req_we_A;
    assign rd_acc_b = acc_b && !req_we_B;
    assign pop_a    = rsp_valid_A && rsp_ready_A;
    assign pop_b    = rsp_valid_B && rsp_ready_B;

    assign ram_ce     = acc_a || acc_b;
    assign ram_we_A   = acc_a && req_we_A;
    assign ram_we_B   = acc_b && req_we_B;
    assign ram_addr_A = acc_a ? req_addr_A : last_addr_a;
    assign ram_addr_B = acc_b ? req_addr_B : last_addr_b;
    assign ram_wd_A   = acc_a ? req_wd_A   : '0;
    assign ram_wd_B   = acc_b ? req_wd_B   : '0;
    assign ram_mask_A = acc_a ? req_mask_A : '0;
    assign ram_mask_B = acc_b ? req_mask_B : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cred_a      <= '0;
            cred_b      <= '0;
            inflight_a  <= 1'b0;
            inflight_b  <= 1'b0;
            last_addr_a <= '0;
            last_addr_b <= '0;
        end else begin
            case ({rd_acc_a, pop_a})
                2'b10:   cred_a <= cred_a + 1'b1;
                2'b01:   cred_a <= cred_a - 1'b1;
                default: cred_a <= cred_a;
            endcase
            case ({rd_acc_b, pop_b})
                2'b10:   cred_b <= cred_b + 1'b1;
                2'b01:   cred_b <= cred_b - 1'b1;
                default: cred_b <= cred_b;
            endcase
            inflight_a <= rd_acc_a;
            inflight_b <= rd_acc_b;
            if (acc_a) last_addr_a <= req_addr_A;
            if (acc_b) last_addr_b <= req_addr_B;
        end
    end

    dpram_arb_rsp_fifo #(.WIDTH(BITS), .DEPTH(RSP_DEPTH)) u_rsp_a (
        .clk(clk), .rst_n(rst_n), .push(inflight_a), .push_data(ram_rd_A),
        .pop(pop_a), .pop_vld(rsp_valid_A), .pop_data(rsp_data_A), .count(cnt_a)
    );

    dpram_arb_rsp_fifo #(.WIDTH(BITS), .DEPTH(RSP_DEPTH)) u_rsp_b (
        .clk(clk), .rst_n(rst_n), .push(inflight_b), .push_data(ram_rd_B),
        .pop(pop_b), .pop_vld(rsp_valid_B), .pop_data(rsp_data_B), .count(cnt_b)
    );

    // Every queued response was paid for by a credit that has not been returned yet.
    a_cred_covers_fifo: assert property (@(posedge clk) disable iff (!rst_n)
        (cnt_a <= cred_a) && (cnt_b <= cred_b));

`ifdef DPRAM_ARB_STATS_EN
    logic [32:0] reads_sum;
    assign reads_sum = {1'b0, stat_reads} + 33'(rd_acc_a) + 33'(rd_acc_b);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_conflict <= '0;
            stat_reads    <= '0;
        end else begin
            if (conflict && stat_conflict != 16'hFFFF) stat_conflict <= stat_conflict + 1'b1;
            stat_reads <= reads_sum[32] ? 32'hFFFF_FFFF : reads_sum[31:0];
        end
    end
`endif

endmodule

// File: tb/tb_dpram_arb_front.sv
// Directed bench for dpram_arb_front with a behavioural 2048x32 dual-port macro model.
module tb_dpram_arb_front;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid_A, req_ready_A, req_we_A;
    logic [10:0] req_addr_A;
    logic [31:0] req_wd_A, req_mask_A;
    logic        req_valid_B, req_ready_B, req_we_B;
    logic [10:0] req_addr_B;
    logic [31:0] req_wd_B, req_mask_B;
    logic        rsp_valid_A, rsp_ready_A, rsp_valid_B, rsp_ready_B;
    logic [31:0] rsp_data_A, rsp_data_B;
    logic        ram_ce, ram_we_A, ram_we_B;
    logic [10:0] ram_addr_A, ram_addr_B;
    logic [31:0] ram_wd_A, ram_wd_B, ram_mask_A, ram_mask_B;
    logic [31:0] ram_rd_A, ram_rd_B;
`ifdef DPRAM_ARB_STATS_EN
    logic [15:0] stat_conflict;
    logic [31:0] stat_reads;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dpram_arb_front dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid_A(req_valid_A), .req_ready_A(req_ready_A), .req_we_A(req_we_A),
        .req_addr_A(req_addr_A), .req_wd_A(req_wd_A), .req_mask_A(req_mask_A),
        .req_valid_B(req_valid_B), .req_ready_B(req_ready_B), .req_we_B(req_we_B),
        .req_addr_B(req_addr_B), .req_wd_B(req_wd_B), .req_mask_B(req_mask_B),
        .rsp_valid_A(rsp_valid_A), .rsp_ready_A(rsp_ready_A), .rsp_data_A(rsp_data_A),
        .rsp_valid_B(rsp_valid_B), .rsp_ready_B(rsp_ready_B), .rsp_data_B(rsp_data_B),
        .ram_ce(ram_ce),
        .ram_we_A(ram_we_A), .ram_addr_A(ram_addr_A), .ram_wd_A(ram_wd_A), .ram_mask_A(ram_mask_A),
        .ram_we_B(ram_we_B), .ram_addr_B(ram_addr_B), .ram_wd_B(ram_wd_B), .ram_mask_B(ram_mask_B),
        .ram_rd_A(ram_rd_A), .ram_rd_B(ram_rd_B)
`ifdef DPRAM_ARB_STATS_EN
        , .stat_conflict(stat_conflict), .stat_reads(stat_reads)
`endif
    );

    // Macro model: masked writes land at the edge, read data appears the cycle after.
    logic [31:0] mem [0:2047];
    always @(posedge clk) begin
        if (ram_ce) begin
            if (ram_we_A) mem[ram_addr_A] <= (mem[ram_addr_A] & ~ram_mask_A) | (ram_wd_A & ram_mask_A);
            if (ram_we_B) mem[ram_addr_B] <= (mem[ram_addr_B] & ~ram_mask_B) | (ram_wd_B & ram_mask_B);
            ram_rd_A <= mem[ram_addr_A];
            ram_rd_B <= mem[ram_addr_B];
        end else begin
            ram_rd_A <= 32'hX;
            ram_rd_B <= 32'hX;
        end
    end

    task automatic idle_all();
        req_valid_A = 0; req_we_A = 0; req_addr_A = '0; req_wd_A = '0; req_mask_A = '0;
        req_valid_B = 0; req_we_B = 0; req_addr_B = '0; req_wd_B = '0; req_mask_B = '0;
        rsp_ready_A = 0; rsp_ready_B = 0;
    endtask

    task automatic wr_a(input logic [10:0] addr, input logic [31:0] data, input logic [31:0] mask);
        req_valid_A = 1; req_we_A = 1; req_addr_A = addr; req_wd_A = data; req_mask_A = mask;
        @(negedge clk);
        req_valid_A = 0; req_we_A = 0;
    endtask

    task automatic test_reset();
        rst_n = 0;
        idle_all();
        req_valid_A = 1; req_we_A = 1; req_valid_B = 1;
        repeat (2) @(negedge clk);
        checks++;
        if ({req_ready_A, req_ready_B, rsp_valid_A, rsp_valid_B, ram_ce, ram_we_A, ram_we_B} !== 7'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b required 0000000",
                {req_ready_A, req_ready_B, rsp_valid_A, rsp_valid_B, ram_ce, ram_we_A, ram_we_B});
        end
        checks++;
        if ({ram_addr_A, ram_addr_B} !== 22'h0) begin
            errors++;
            $display("FAIL reset_addr: got %h/%h required 000/000", ram_addr_A, ram_addr_B);
        end
        idle_all();
        rst_n = 1;
        @(negedge clk);
    endtask

    task automatic test_write_read();
        wr_a(11'h005, 32'hDEADBEEF, 32'hFFFFFFFF);
        req_valid_A = 1; req_we_A = 0; req_addr_A = 11'h005;
        #1;
        checks++;
        if ({req_ready_A, ram_ce, ram_we_A, ram_addr_A} !== {1'b1, 1'b1, 1'b0, 11'h005}) begin
            errors++;
            $display("FAIL rd_issue: got rdy=%b ce=%b we=%b addr=%h required 1 1 0 005",
                req_ready_A, ram_ce, ram_we_A, ram_addr_A);
        end
        @(negedge clk);
        req_valid_A = 0;
        checks++;
        if (rsp_valid_A !== 1'b0) begin
            errors++;
            $display("FAIL rd_early: rsp_valid_A=%b required 0 one cycle after accept", rsp_valid_A);
        end
        @(negedge clk);
        checks++;
        if (rsp_valid_A !== 1'b1 || rsp_data_A !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL rd_data: got v=%b d=%h required 1 deadbeef", rsp_valid_A, rsp_data_A);
        end
        rsp_ready_A = 1;
        @(negedge clk);
        rsp_ready_A = 0;
        checks++;
        if (rsp_valid_A !== 1'b0) begin
            errors++;
            $display("FAIL rd_pop: rsp_valid_A=%b required 0 after pop", rsp_valid_A);
        end
    endtask

    task automatic test_mask_cross();
        wr_a(11'h005, 32'hAAAAAAAA, 32'hFFFFFFFF);
        wr_a(11'h005, 32'h12345678, 32'h0000FFFF);
        req_valid_B = 1; req_we_B = 0; req_addr_B = 11'h005;
        #1;
        checks++;
        if (req_ready_B !== 1'b1) begin
            errors++;
            $display("FAIL mask_rdy: req_ready_B=%b required 1", req_ready_B);
        end
        @(negedge clk);
        req_valid_B = 0;
        @(negedge clk);
        checks++;
        if (rsp_valid_B !== 1'b1 || rsp_data_B !== 32'hAAAA5678) begin
            errors++;
            $display("FAIL mask_data: got v=%b d=%h required 1 aaaa5678", rsp_valid_B, rsp_data_B);
        end
        rsp_ready_B = 1;
        @(negedge clk);
        rsp_ready_B = 0;
    endtask

    task automatic test_conflict();
        req_valid_A = 1; req_we_A = 1; req_addr_A = 11'h7FF; req_wd_A = 32'hCAFEF00D; req_mask_A = '1;
        req_valid_B = 1; req_we_B = 0; req_addr_B = 11'h7FF;
        #1;
        checks++;
        if ({req_ready_A, req_ready_B} !== 2'b10) begin
            errors++;
            $display("FAIL conflict_rdy: got A=%b B=%b required A=1 B=0", req_ready_A, req_ready_B);
        end
        @(negedge clk);
        req_valid_A = 0; req_we_A = 0;
        #1;
        checks++;
        if (req_ready_B !== 1'b1) begin
            errors++;
            $display("FAIL conflict_retry: req_ready_B=%b required 1", req_ready_B);
        end
        @(negedge clk);
        req_valid_B = 0;
        @(negedge clk);
        checks++;
        if (rsp_valid_B !== 1'b1 || rsp_data_B !== 32'hCAFEF00D) begin
            errors++;
            $display("FAIL conflict_data: got v=%b d=%h required 1 cafef00d", rsp_valid_B, rsp_data_B);
        end
`ifdef DPRAM_ARB_STATS_EN
        checks++;
        if (stat_conflict !== 16'd1) begin
            errors++;
            $display("FAIL stat_conflict: got %0d required 1", stat_conflict);
        end
`endif
        rsp_ready_B = 1;
        @(negedge clk);
        rsp_ready_B = 0;
    endtask

    task automatic test_credit();
        for (int i = 0; i < 6; i++) wr_a(11'(11'h020 + i), 32'hA0000000 + i, 32'hFFFFFFFF);
        for (int i = 0; i < 6; i++) begin
            logic exp_rdy;
            exp_rdy = (i < 4);
            req_valid_A = 1; req_we_A = 0; req_addr_A = 11'(11'h020 + i);
            #1;
            checks++;
            if (req_ready_A !== exp_rdy) begin
                errors++;
                $display("FAIL credit_rdy[%0d]: got %b required %b", i, req_ready_A, exp_rdy);
            end
            @(negedge clk);
        end
        req_we_A = 1;
        #1;
        checks++;
        if (req_ready_A !== 1'b1) begin
            errors++;
            $display("FAIL credit_write: req_ready_A=%b required 1 for write with no credit", req_ready_A);
        end
        req_valid_A = 0; req_we_A = 0;
        rsp_ready_A = 1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (rsp_valid_A !== 1'b1 || rsp_data_A !== 32'hA0000000 + i) begin
                errors++;
                $display("FAIL credit_data[%0d]: got v=%b d=%h required 1 %h",
                    i, rsp_valid_A, rsp_data_A, 32'hA0000000 + i);
            end
            @(negedge clk);
        end
        rsp_ready_A = 0;
        checks++;
        if (rsp_valid_A !== 1'b0) begin
            errors++;
            $display("FAIL credit_drain: rsp_valid_A=%b required 0", rsp_valid_A);
        end
    endtask

    task automatic test_back_to_back();
        rsp_ready_A = 1;
        for (int k = 0; k < 6; k++) begin
            req_valid_A = (k < 4); req_we_A = 0; req_addr_A = 11'(11'h020 + k);
            #1;
            if (k < 4) begin
                checks++;
                if (req_ready_A !== 1'b1) begin
                    errors++;
                    $display("FAIL b2b_rdy[%0d]: got %b required 1", k, req_ready_A);
                end
            end
            if (k >= 2) begin
                checks++;
                if (rsp_valid_A !== 1'b1 || rsp_data_A !== 32'hA0000000 + k - 2) begin
                    errors++;
                    $display("FAIL b2b_data[%0d]: got v=%b d=%h required 1 %h",
                        k, rsp_valid_A, rsp_data_A, 32'hA0000000 + k - 2);
                end
            end
            @(negedge clk);
        end
        req_valid_A = 0;
        rsp_ready_A = 0;
    endtask

    task automatic test_dual_read();
        wr_a(11'h100, 32'h0BADF00D, 32'hFFFFFFFF);
        req_valid_A = 1; req_we_A = 0; req_addr_A = 11'h100;
        req_valid_B = 1; req_we_B = 0; req_addr_B = 11'h100;
        #1;
        checks++;
        if ({req_ready_A, req_ready_B} !== 2'b11) begin
            errors++;
            $display("FAIL dual_rdy: got A=%b B=%b required 1 1", req_ready_A, req_ready_B);
        end
        @(negedge clk);
        req_valid_A = 0; req_valid_B = 0;
        @(negedge clk);
        checks++;
        if ({rsp_valid_A, rsp_valid_B} !== 2'b11 || rsp_data_A !== 32'h0BADF00D
            || rsp_data_B !== 32'h0BADF00D) begin
            errors++;
            $display("FAIL dual_data: got v=%b%b A=%h B=%h required 11 0badf00d 0badf00d",
                rsp_valid_A, rsp_valid_B, rsp_data_A, rsp_data_B);
        end
        rsp_ready_A = 1; rsp_ready_B = 1;
        @(negedge clk);
        rsp_ready_A = 0; rsp_ready_B = 0;
    endtask

    task automatic test_reset_inflight();
        req_valid_A = 1; req_we_A = 0; req_addr_A = 11'h020;
        @(negedge clk);
        rst_n = 0;
        #1;
        checks++;
        if ({req_ready_A, rsp_valid_A, ram_ce, ram_we_A} !== 4'b0 || ram_addr_A !== 11'h0) begin
            errors++;
            $display("FAIL rst_hold: got rdy=%b v=%b ce=%b we=%b addr=%h required 0 0 0 0 000",
                req_ready_A, rsp_valid_A, ram_ce, ram_we_A, ram_addr_A);
        end
        req_valid_A = 0;
        repeat (2) @(negedge clk);
        rst_n = 1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (rsp_valid_A !== 1'b0) begin
                errors++;
                $display("FAIL rst_drop[%0d]: rsp_valid_A=%b required 0", i, rsp_valid_A);
            end
        end
        req_valid_A = 1;
        #1;
        checks++;
        if (req_ready_A !== 1'b1) begin
            errors++;
            $display("FAIL rst_cred: req_ready_A=%b required 1 after reset", req_ready_A);
        end
        req_valid_A = 0;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_mask_cross();
        test_conflict();
        test_credit();
        test_back_to_back();
        test_dual_read();
        test_reset_inflight();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dpram_arb_front.md
# dpram_arb_front

Request front-end for the 2048x32 dual-port fake SRAM macro. Accepts independent valid/ready read/write requests on two client ports (A, B), detects same-address cross-port conflicts, and drives the macro's address, write-enable, data, mask and chip-enable pins. It captures the macro's 1-cycle read data into per-port response FIFOs so clients may back-pressure responses. It sits directly upstream of the SRAM macro and is the only block allowed to drive its pins.

## Interface
- `ADDR_WIDTH`, 11: word address width.
- `BITS`, 32: data and mask width.
- `RSP_DEPTH`, 4: entries per response FIFO; must be ≥3 for full read throughput.
- `clk` in 1: single clock; the SRAM macro shares it.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid_A/B` in 1: request valid per port.
- `req_ready_A/B` out 1: request accepted when valid && ready.
- `req_we_A/B` in 1: 1 = write, 0 = read.
- `req_addr_A/B` in ADDR_WIDTH: word address.
- `req_wd_A/B` in BITS: write data.
- `req_mask_A/B` in BITS: per-bit write mask (1 = write the bit).
- `rsp_valid_A/B` out 1: read data available.
- `rsp_ready_A/B` in 1: client pops the response.
- `rsp_data_A/B` out BITS: read data.
- `ram_ce` out 1: drives macro `ce_in`.
- `ram_we_A/B`, `ram_addr_A/B`, `ram_wd_A/B`, `ram_mask_A/B` out: drive the corresponding macro pins.
- `ram_rd_A/B` in BITS: from macro `rd_out_A/B`.

## Operation
- Credit count per port, `cred`, 0..RSP_DEPTH:
  - Counts reads in flight plus FIFO occupancy.
  - +1 on an accepted read; -1 on a response pop; both in the same cycle leaves it unchanged.
- `req_ready_X = (cred_X < RSP_DEPTH) || req_we_X`. Writes never need credit.
- Conflict: both ports valid and otherwise ready, `addr_A == addr_B`, and at least one port is a write.
  - A wins; `req_ready_B` = 0 that cycle.
  - Two reads to the same address never conflict.
- Issue: an accepted request on port X drives `ram_we_X`/`ram_addr_X`/`ram_wd_X`/`ram_mask_X` combinationally in the same cycle.
- An idle port drives `ram_we_X` = 0, and `ram_addr_X` holds its last issued value (never X).
- `ram_ce` = 1 iff at least one port is accepted this cycle. Otherwise 0, so the macro outputs X.
- Read return:
  - A per-port registered flag `inflight_X` is set when a read is accepted.
  - The cycle after acceptance, `ram_rd_X` is pushed into FIFO X.
  - The macro's read data for a port that was idle or writing is discarded.
- Write-then-read across ports on consecutive cycles returns the new data (macro write lands at the issuing edge).
- Responses are returned in order per port; the two ports are independent.
- Reset (`rst_n` low, any time):
  - Outputs: `req_ready` 0, `rsp_valid` 0, `ram_ce` 0, `ram_we` 0, `ram_addr` 0.
  - State: credits 0; FIFOs emptied.
  - Reads in flight are dropped, and no response is produced after reset release.

## Timing
- Read latency: accept at cycle T, macro data at T+1, `rsp_valid` at T+2 at the earliest.
- Throughput: one read per port per cycle when `rsp_ready` is held high and `RSP_DEPTH` ≥3.
- Writes complete at the accepting edge and produce no response.
- FIFO: registered output, no bypass. A push into a full FIFO cannot occur (credit guarantee); an assertion flags it.
- `req_ready` has a combinational path from `req_valid`/`req_addr`/`req_we` of both ports (conflict check). It has no path from `rsp_ready`.

## Configuration
- `DPRAM_ARB_STATS_EN`:
  - Defined: adds outputs `stat_conflict` (16 b) and `stat_reads` (32 b). Both are saturating counters of conflict stalls and accepted reads, reset to 0.
  - Undefined: the ports and logic are absent.

## Structure
- Package `dpram_arb_pkg`: `ADDR_WIDTH`/`BITS` defaults, typedef `dpram_req_t` {we, addr, wd, mask}, and the conflict-check function.
- Sub-module `dpram_arb_rsp_fifo`: parameterized synchronous FIFO with count output, instantiated once per port.

## Test plan
- Port A writes 0xDEADBEEF to addr 0x005 with mask 0xFFFFFFFF, then reads 0x005 → `rsp_data_A` = 0xDEADBEEF, `rsp_valid_A` two cycles after the read accept.
- A writes 0x5 with mask 0x0000FFFF, data 0x12345678, over 0xAAAAAAAA; B reads 0x5 the next cycle → `rsp_data_B` = 0xAAAA5678.
- Same-cycle A write and B read of 0x7FF → `req_ready_B` = 0 for one cycle; B's read then returns A's data. With `DPRAM_ARB_STATS_EN` defined, `stat_conflict` = 1.
- A issues 6 back-to-back reads with `rsp_ready_A` = 0, `RSP_DEPTH` = 4 → exactly 4 accepted and `req_ready_A` drops. Raising `rsp_ready` yields in-order data with no loss.
- Both ports read addr 0x100 in the same cycle → both accepted, both return identical data.
- Assert `rst_n` low one cycle after a read accept → no `rsp_valid` ever appears for it; all outputs hold reset values during reset.
